// File: rtl/digit_recognition_core.sv
// Bounding-box and stroke-feature digit recogniser driven by an external pixel address generator.
// Three frames: row scan finds top/bottom, column scan finds left/right, a final row scan extracts features.
module digit_recognition_core #(
  parameter int H_PIX = 640,
  parameter int V_PIX = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  iRow,
  input  logic [9:0]  iCol,
  input  logic        iHscan,
  input  logic        iVscan,
  input  logic [9:0]  iPixel,
  output logic [19:0] oRow,
  output logic [19:0] oCol,
  output logic [1:0]  oFinish,
  output logic [9:0]  oBWrgb,
  output logic [5:0]  oRecognition,
  output logic [3:0]  oDigital,
  output logic        oFin
);

  typedef enum logic [1:0] {S_TB, S_LR, S_REC, S_DONE} phase_e;

  localparam logic [9:0] LAST_ROW = 10'(V_PIX - 1);
  localparam logic [9:0] LAST_COL = 10'(H_PIX - 1);

  phase_e     phase_q, phase_d;
  logic [9:0] top_q, top_d, bottom_q, bottom_d, left_q, left_d, right_q, right_d;
  logic       row_found_q, row_found_d, col_found_q, col_found_d;
  logic [1:0] cross_q, cross_d;
  logic       prev_q, prev_d, prev_eff;
  logic       ul_q, ul_d, ur_q, ur_d, ll_q, ll_d, lr_q, lr_d;
  logic [5:0] rec_q, rec_d;
  logic [3:0] digit_q, digit_d;

  logic       fg, last_pix, in_rows, row_en, col_en, rec_en, rec_end;
  logic [9:0] h, mid, r1, r2;
  logic [10:0] width, height;
  logic       narrow, on_border;
  logic [5:0] feat_d;

  assign fg       = (iPixel == 10'h3FF);
  assign last_pix = (iRow == LAST_ROW) && (iCol == LAST_COL);
  assign in_rows  = (iRow >= top_q) && (iRow <= bottom_q);

  // Each phase listens only to its own scan strobe; a stray strobe of the other kind is ignored.
  assign row_en  = (phase_q == S_TB)  && iHscan;
  assign col_en  = (phase_q == S_LR)  && iVscan && in_rows;
  assign rec_en  = (phase_q == S_REC) && iHscan;
  assign rec_end = rec_en && last_pix;

  assign h      = bottom_q - top_q;
  assign mid    = 10'(({1'b0, left_q} + {1'b0, right_q}) >> 1);
  assign r1     = top_q + 10'(h >> 2);
  assign r2     = top_q + 10'(({2'b00, h} * 12'd3) >> 2);
  assign width  = {1'b0, right_q} - {1'b0, left_q} + 11'd1;
  assign height = {1'b0, h} + 11'd1;
  assign narrow = width < (height >> 2);

  assign on_border = (((iRow == top_q) || (iRow == bottom_q)) && (iCol >= left_q) && (iCol <= right_q))
                  || (((iCol == left_q) || (iCol == right_q)) && in_rows);

  function automatic logic [3:0] decode(input logic [5:0] f);
    case (f)
      6'b10_1111: decode = 4'd0;
      6'b11_0110: decode = 4'd2;
      6'b11_0101: decode = 4'd3;
      6'b01_1101: decode = 4'd4;
      6'b11_1001: decode = 4'd5;
      6'b11_1011: decode = 4'd6;
      6'b01_0101: decode = 4'd7;
      6'b11_1111: decode = 4'd8;
      6'b11_1101: decode = 4'd9;
      default:    decode = 4'hF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) phase_q <= S_TB;
    else      phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      S_TB:    if (iHscan && last_pix) phase_d = S_LR;
      S_LR:    if (iVscan && last_pix) phase_d = S_REC;
      S_REC:   if (iHscan && last_pix) phase_d = S_DONE;
      default: phase_d = S_DONE;
    endcase
  end

  always_comb begin
    oFinish = 2'b00;
    oFin    = 1'b0;
    oBWrgb  = 10'h000;
    case (phase_q)
      S_LR:   oFinish = 2'b01;
      S_REC: begin
        oFinish = 2'b11;
        oBWrgb  = on_border ? 10'h3FF : iPixel;
      end
      S_DONE: begin
        oFinish = 2'b11;
        oFin    = 1'b1;
      end
      default: ;
    endcase
  end

  // Bounding box: top is the first foreground row, bottom the last; columns are min/max so scan order is irrelevant.
  always_comb begin
    top_d       = top_q;
    bottom_d    = bottom_q;
    left_d      = left_q;
    right_d     = right_q;
    row_found_d = row_found_q;
    col_found_d = col_found_q;
    if (row_en && fg) begin
      if (!row_found_q) top_d = iRow;
      bottom_d    = iRow;
      row_found_d = 1'b1;
    end
    if (col_en && fg) begin
      if (!col_found_q || (iCol < left_q))  left_d  = iCol;
      if (!col_found_q || (iCol > right_q)) right_d = iCol;
      col_found_d = 1'b1;
    end
  end

  // The previous-pixel history at column mid is forced to background on the top row of the box.
  always_comb begin
    cross_d  = cross_q;
    prev_d   = prev_q;
    ul_d     = ul_q;
    ur_d     = ur_q;
    ll_d     = ll_q;
    lr_d     = lr_q;
    prev_eff = (iRow == top_q) ? 1'b0 : prev_q;
    if (rec_en) begin
      if ((iCol == mid) && in_rows) begin
        if (fg && !prev_eff && (cross_q != 2'd3)) cross_d = cross_q + 2'd1;
        prev_d = fg;
      end
      if (fg && (iRow == r1)) begin
        if ((iCol >= left_q) && (iCol < mid))   ul_d = 1'b1;
        if ((iCol > mid) && (iCol <= right_q))  ur_d = 1'b1;
      end
      if (fg && (iRow == r2)) begin
        if ((iCol >= left_q) && (iCol < mid))   ll_d = 1'b1;
        if ((iCol > mid) && (iCol <= right_q))  lr_d = 1'b1;
      end
    end
    feat_d  = {cross_d, ul_d, ur_d, ll_d, lr_d};
    rec_d   = rec_q;
    digit_d = digit_q;
    if (rec_end) begin
      rec_d   = feat_d;
      digit_d = narrow ? 4'd1 : decode(feat_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      top_q       <= '0;
      bottom_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      row_found_q <= 1'b0;
      col_found_q <= 1'b0;
      cross_q     <= '0;
      prev_q      <= 1'b0;
      ul_q        <= 1'b0;
      ur_q        <= 1'b0;
      ll_q        <= 1'b0;
      lr_q        <= 1'b0;
      rec_q       <= '0;
      digit_q     <= 4'hF;
    end else begin
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      left_q      <= left_d;
      right_q     <= right_d;
      row_found_q <= row_found_d;
      col_found_q <= col_found_d;
      cross_q     <= cross_d;
      prev_q      <= prev_d;
      ul_q        <= ul_d;
      ur_q        <= ur_d;
      ll_q        <= ll_d;
      lr_q        <= lr_d;
      rec_q       <= rec_d;
      digit_q     <= digit_d;
    end
  end

  assign oRow         = {top_q, bottom_q};
  assign oCol         = {left_q, right_q};
  assign oRecognition = rec_q;
  assign oDigital     = digit_q;

endmodule

// File: tb/tb_digit_recognition_core.sv
// Directed bench: shapes are presented as a sparse raster (only listed rows/cols, in scan order),
// which keeps every edge, stroke and probe point while frames stay a few hundred cycles long.
module tb_digit_recognition_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  iRow = '0, iCol = '0, iPixel = '0;
  logic        iHscan = 1'b0, iVscan = 1'b0;
  logic [19:0] oRow, oCol;
  logic [1:0]  oFinish;
  logic [9:0]  oBWrgb;
  logic [5:0]  oRecognition;
  logic [3:0]  oDigital;
  logic        oFin;

  int n_tests = 0;
  int n_fail  = 0;

  digit_recognition_core dut (
    .clk(clk), .rst(rst), .iRow(iRow), .iCol(iCol), .iHscan(iHscan), .iVscan(iVscan),
    .iPixel(iPixel), .oRow(oRow), .oCol(oCol), .oFinish(oFinish), .oBWrgb(oBWrgb),
    .oRecognition(oRecognition), .oDigital(oDigital), .oFin(oFin)
  );

  always #5 clk = ~clk;

  int rows_l[18] = '{0, 10, 50, 99, 100, 109, 110, 149, 194, 195, 204, 205, 249, 289, 290, 299, 300, 479};
  int cols_l[21] = '{0, 20, 50, 199, 200, 209, 210, 250, 268, 269, 270, 299, 300, 304, 309, 310, 329,
                     330, 339, 340, 639};

  typedef struct {
    int         shape;
    logic [19:0] exp_row;
    logic [19:0] exp_col;
    logic [5:0]  exp_rec;
    logic [3:0]  exp_dig;
    int          pa_r, pa_c;
    logic [9:0]  pa_exp;
    int          pb_r, pb_c;
    logic [9:0]  pb_exp;
  } vec_t;

  vec_t vecs[6];

  // 0 empty, 1 dot, 2 ring, 3 bar, 4 seven, 5 eight (ring plus middle bar)
  function automatic bit fg(input int s, input int r, input int c);
    bit outer, inner, ring;
    outer = (r >= 100 && r <= 299 && c >= 200 && c <= 339);
    inner = (r >= 110 && r <= 289 && c >= 210 && c <= 329);
    ring  = outer && !inner;
    case (s)
      1: fg = (r == 10 && c == 20);
      2: fg = ring;
      3: fg = (r >= 100 && r <= 299 && c >= 300 && c <= 309);
      4: fg = (r >= 100 && r <= 109 && c >= 200 && c <= 339) || (r >= 100 && r <= 299 && c >= 330 && c <= 339);
      5: fg = ring || (r >= 195 && r <= 204 && c >= 200 && c <= 339);
      default: fg = 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input int c, input logic hs, input logic vs, input logic [9:0] pix);
    @(negedge clk);
    iRow   = 10'(r);
    iCol   = 10'(c);
    iHscan = hs;
    iVscan = vs;
    iPixel = pix;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; iHscan = 1'b0; iVscan = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Row-major frame; rec selects whether the box overlay is expected on the probe points.
  task automatic row_scan(input vec_t v, input bit rec, input logic [1:0] pre_fin);
    for (int i = 0; i < 18; i++) begin
      for (int j = 0; j < 21; j++) begin
        drive(rows_l[i], cols_l[j], 1'b1, 1'b0, fg(v.shape, rows_l[i], cols_l[j]) ? 10'h3FF : 10'h000);
        #1;
        if (rows_l[i] == v.pa_r && cols_l[j] == v.pa_c)
          check(rec ? "bw_probe_a" : "bw_off_a", oBWrgb, rec ? v.pa_exp : 10'h000);
        if (rows_l[i] == v.pb_r && cols_l[j] == v.pb_c)
          check(rec ? "bw_probe_b" : "bw_off_b", oBWrgb, rec ? v.pb_exp : 10'h000);
        if (i == 17 && j == 20) check("finish_before_last", oFinish, pre_fin);
      end
    end
  endtask

  task automatic col_scan(input int shape, input int ncols);
    for (int j = 0; j < ncols; j++)
      for (int i = 0; i < 18; i++)
        drive(rows_l[i], cols_l[j], 1'b0, 1'b1, fg(shape, rows_l[i], cols_l[j]) ? 10'h3FF : 10'h000);
  endtask

  task automatic run_test(input vec_t v, input bit skip_reset);
    if (!skip_reset) do_reset();
    @(negedge clk);
    check("rst_orow", oRow, 20'h0);
    check("rst_finish", oFinish, 2'b00);
    check("rst_digit", oDigital, 4'hF);
    check("rst_rec", oRecognition, 6'h0);
    check("rst_fin", oFin, 1'b0);
    // A foreground pixel under the wrong strobe must not disturb the row bounds.
    drive(5, 5, 1'b0, 1'b1, 10'h3FF);
    row_scan(v, 1'b0, 2'b00);
    @(negedge clk);
    iHscan = 1'b0;
    check("p1_finish", oFinish, 2'b01);
    check("p1_orow", oRow, v.exp_row);
    check("p1_ocol", oCol, 20'h0);
    drive(int'(v.exp_row[19:10]), 5, 1'b1, 1'b0, 10'h3FF);
    col_scan(v.shape, 21);
    @(negedge clk);
    iVscan = 1'b0;
    check("p2_finish", oFinish, 2'b11);
    check("p2_ocol", oCol, v.exp_col);
    check("p2_orow", oRow, v.exp_row);
    check("p2_fin", oFin, 1'b0);
    row_scan(v, 1'b1, 2'b11);
    @(negedge clk);
    iHscan = 1'b0;
    check("rec_fin", oFin, 1'b1);
    check("rec_vector", oRecognition, v.exp_rec);
    check("rec_digit", oDigital, v.exp_dig);
    check("rec_finish", oFinish, 2'b11);
    repeat (3) @(negedge clk);
    check("fin_sticky", oFin, 1'b1);
  endtask

  initial begin
    vecs[0] = '{0, 20'h0, 20'h0, 6'b00_0000, 4'hF, 0, 0, 10'h3FF, 100, 250, 10'h000};
    vecs[1] = '{1, {10'd10, 10'd10}, {10'd20, 10'd20}, 6'b01_0000, 4'hF, 10, 20, 10'h3FF, 10, 50, 10'h000};
    vecs[2] = '{2, {10'd100, 10'd299}, {10'd200, 10'd339}, 6'b10_1111, 4'd0, 100, 250, 10'h3FF, 50, 50, 10'h000};
    vecs[3] = '{3, {10'd100, 10'd299}, {10'd300, 10'd309}, 6'b01_1111, 4'd1, 299, 304, 10'h3FF, 149, 250, 10'h000};
    vecs[4] = '{4, {10'd100, 10'd299}, {10'd200, 10'd339}, 6'b01_0101, 4'd7, 299, 200, 10'h3FF, 149, 250, 10'h000};
    vecs[5] = '{5, {10'd100, 10'd299}, {10'd200, 10'd339}, 6'b11_1111, 4'd8, 195, 250, 10'h3FF, 149, 250, 10'h000};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) run_test(vecs[k], 1'b0);

    // Reset in the middle of the column scan, then a full rescan of the ring.
    do_reset();
    row_scan(vecs[2], 1'b0, 2'b00);
    @(negedge clk);
    iHscan = 1'b0;
    col_scan(2, 10);
    @(negedge clk);
    rst = 1'b0;
    iVscan = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_finish", oFinish, 2'b00);
    check("midrst_orow", oRow, 20'h0);
    check("midrst_ocol", oCol, 20'h0);
    check("midrst_fin", oFin, 1'b0);
    run_test(vecs[2], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
